// File: rtl/acc_cpu_sequencer.sv
// acc_cpu_sequencer: multicycle fetch/decode/execute FSM for the 16-bit accumulator CPU.
// Optional build macro ILLEGAL_TRAP_EN: undefined opcodes trap to HALT and set illegal_op.
module acc_cpu_sequencer #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 'h100,
  parameter logic [3:0] ALU_ADD_SEL = 4'h0,
  parameter logic [3:0] ALU_SUB_SEL = 4'h1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_sel,
  input  logic [DATA_WIDTH-1:0] alu_out,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ac,
  output logic [DATA_WIDTH-1:0] ir,
  output logic                  busy,
  output logic                  halted,
  output logic                  instr_done
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                  illegal_op
`endif
);

  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUBT  = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h7;
  localparam logic [3:0] OP_SKIP  = 4'h8;
  localparam logic [3:0] OP_JUMP  = 4'h9;
  localparam logic [3:0] OP_CLEAR = 4'hA;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_RD,
    S_INCR,
    S_OP_ADDR,
    S_OP_RD,
    S_ALU,
    S_WBACK,
    S_ST_PREP,
    S_WRITE,
    S_EXEC1,
    S_HALT
  } state_t;

  state_t state;
  state_t state_nxt;
  state_t dispatch;

  logic [DATA_WIDTH-1:0] mbr;
  logic [3:0]            opc;
  logic [ADDR_WIDTH-1:0] pc_addr;
  logic [ADDR_WIDTH-1:0] ir_addr;

  logic is_load;
  logic is_store;
  logic is_add;
  logic is_sub;
  logic is_halt;
  logic is_skip;
  logic is_jump;
  logic is_clear;
  logic ac_neg;
  logic ac_zero;
  logic skip_take;

  assign opc      = ir[15:12];
  assign pc_addr  = pc[ADDR_WIDTH-1:0];
  assign ir_addr  = ADDR_WIDTH'(ir[11:0]);

  assign is_load  = (opc == OP_LOAD);
  assign is_store = (opc == OP_STORE);
  assign is_add   = (opc == OP_ADD);
  assign is_sub   = (opc == OP_SUBT);
  assign is_halt  = (opc == OP_HALT);
  assign is_skip  = (opc == OP_SKIP);
  assign is_jump  = (opc == OP_JUMP);
  assign is_clear = (opc == OP_CLEAR);

  assign ac_neg   = ac[DATA_WIDTH-1];
  assign ac_zero  = (ac == '0);

  // SKIPCOND treats AC as two's-complement
  always_comb begin
    skip_take = 1'b0;
    unique case (ir[1:0])
      2'b00:   skip_take = ac_neg;
      2'b01:   skip_take = ac_zero;
      2'b10:   skip_take = !ac_neg && !ac_zero;
      default: skip_take = 1'b0;
    endcase
  end

  always_comb begin
    dispatch = S_EXEC1;
    unique case (1'b1)
      is_load, is_add, is_sub:     dispatch = S_OP_ADDR;
      is_store:                    dispatch = S_ST_PREP;
      is_halt:                     dispatch = S_HALT;
      is_skip, is_jump, is_clear:  dispatch = S_EXEC1;
      default: begin
`ifdef ILLEGAL_TRAP_EN
        dispatch = S_HALT;
`else
        dispatch = S_EXEC1;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (start) state_nxt = S_FETCH;
      S_FETCH:    state_nxt = S_FETCH_RD;
      S_FETCH_RD: state_nxt = S_INCR;
      S_INCR:     state_nxt = dispatch;
      S_OP_ADDR:  state_nxt = S_OP_RD;
      S_OP_RD:    state_nxt = is_load ? S_WBACK : S_ALU;
      S_ALU:      state_nxt = S_WBACK;
      S_ST_PREP:  state_nxt = S_WRITE;
      S_WBACK:    state_nxt = S_FETCH;
      S_WRITE:    state_nxt = S_FETCH;
      S_EXEC1:    state_nxt = S_FETCH;
      S_HALT:     state_nxt = S_HALT;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs; alu_sel stays valid through WBACK where AC captures alu_out
  always_comb begin
    mem_addr   = pc_addr;
    mem_oe     = 1'b0;
    mem_we     = 1'b0;
    alu_sel    = ALU_ADD_SEL;
    instr_done = 1'b0;
    busy       = 1'b1;
    halted     = 1'b0;
    unique case (state)
      S_IDLE: busy = 1'b0;
      S_FETCH, S_FETCH_RD: mem_oe = 1'b1;
      S_OP_ADDR, S_OP_RD: begin
        mem_oe   = 1'b1;
        mem_addr = ir_addr;
      end
      S_ALU: if (is_sub) alu_sel = ALU_SUB_SEL;
      S_WBACK: begin
        instr_done = 1'b1;
        if (is_sub) alu_sel = ALU_SUB_SEL;
      end
      S_WRITE: begin
        mem_we     = 1'b1;
        mem_addr   = ir_addr;
        instr_done = 1'b1;
      end
      S_EXEC1: instr_done = 1'b1;
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_cs    = mem_oe | mem_we;
  assign mem_wdata = mbr;
  assign alu_a     = ac;
  assign alu_b     = mbr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= RESET_PC;
      ir  <= '0;
      mbr <= '0;
      ac  <= '0;
    end else begin
      unique case (state)
        S_FETCH_RD: ir  <= mem_rdata;
        S_INCR:     pc  <= pc + DATA_WIDTH'(2);
        S_OP_RD:    mbr <= mem_rdata;
        S_ST_PREP:  mbr <= ac;
        S_WBACK:    ac  <= is_load ? mbr : alu_out;
        S_EXEC1: begin
          unique case (1'b1)
            is_skip:  if (skip_take) pc <= pc + DATA_WIDTH'(2);
            is_jump:  pc <= DATA_WIDTH'(ir[11:0]);
            is_clear: ac <= '0;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic is_undef;

  assign is_undef = ~(is_load | is_store | is_add | is_sub |
                      is_halt | is_skip | is_jump | is_clear);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_op <= 1'b0;
    end else if (state == S_INCR && is_undef) begin
      illegal_op <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_acc_cpu_sequencer.sv
// tb_acc_cpu_sequencer: directed table, corner sequences and random programs
// checked against an instruction-level model of the accumulator CPU.
module tb_acc_cpu_sequencer;

  localparam logic [3:0] ADD_SEL = 4'h0;
  localparam logic [3:0] SUB_SEL = 4'h1;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_cs;
  logic        mem_we;
  logic        mem_oe;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_sel;
  logic [15:0] alu_out;
  logic [15:0] pc;
  logic [15:0] ac;
  logic [15:0] ir;
  logic        busy;
  logic        halted;
  logic        instr_done;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal_op;
`endif

  acc_cpu_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_oe     (mem_oe),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .pc         (pc),
    .ac         (ac),
    .ir         (ir),
    .busy       (busy),
    .halted     (halted),
`ifdef ILLEGAL_TRAP_EN
    .illegal_op (illegal_op),
`endif
    .instr_done (instr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign alu_out = (alu_sel == SUB_SEL) ? alu_a - alu_b : alu_a + alu_b;

  logic [15:0] ram [0:4095];

  always @(posedge clk) begin
    if (mem_cs && mem_oe) mem_rdata <= ram[mem_addr];
    if (mem_cs && mem_we) ram[mem_addr] <= mem_wdata;
  end

  int vectors = 0;
  int miscompares = 0;
  int proto_err = 0;

  always @(negedge clk) begin
    if (!rst && ((mem_cs !== (mem_oe | mem_we)) ||
                 (mem_oe && mem_we) || (busy && halted)))
      proto_err <= proto_err + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  int          r_cyc;
  bit          r_done;
  bit          r_hlt;
  int          we_cnt;
  logic [11:0] we_addr;
  logic [15:0] we_data;
  logic [3:0]  sel6;

  // Steps one instruction from its FETCH cycle; on completion returns
  // #1 after the edge that commits it (DUT then sits in FETCH).
  task automatic run_one();
    r_cyc = 0;
    r_done = 1'b0;
    r_hlt = 1'b0;
    we_cnt = 0;
    we_addr = '0;
    we_data = '0;
    sel6 = 4'hx;
    for (int i = 0; i < 20 && !r_done && !r_hlt; i++) begin
      @(negedge clk);
      if (busy) r_cyc++;
      if (mem_we) begin
        we_cnt++;
        we_addr = mem_addr;
        we_data = mem_wdata;
      end
      if (r_cyc == 6 && busy) sel6 = alu_sel;
      if (instr_done) r_done = 1'b1;
      if (halted) r_hlt = 1'b1;
    end
    chk("finished", 32'(r_done | r_hlt), 32'd1);
    if (r_done) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input bit check);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    if (check) begin
      chk("rst_pc", 32'(pc), 32'h100);
      chk("rst_ac", 32'(ac), 32'h0);
      chk("rst_ir", 32'(ir), 32'h0);
      chk("rst_ctl", 32'({mem_cs, mem_we, mem_oe}), 32'h0);
      chk("rst_alu_a", 32'(alu_a), 32'h0);
      chk("rst_alu_b", 32'(alu_b), 32'h0);
      chk("rst_alu_sel", 32'(alu_sel), 32'(ADD_SEL));
      chk("rst_status", 32'({busy, halted, instr_done}), 32'h0);
`ifdef ILLEGAL_TRAP_EN
      chk("rst_illegal", 32'(illegal_op), 32'h0);
`endif
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Instruction-level reference model
  logic [15:0] m_mem [0:4095];
  logic [15:0] m_pc;
  logic [15:0] m_ac;

  task automatic model_step(output int cyc, output bit hlt,
                            output bit wr, output logic [11:0] wa,
                            output logic [15:0] wd);
    logic [15:0] ins;
    logic [11:0] a;
    logic signed [15:0] sac;
    bit take;
    ins = m_mem[m_pc[11:0]];
    a = ins[11:0];
    m_pc = m_pc + 16'd2;
    cyc = 4;
    hlt = 1'b0;
    wr = 1'b0;
    wa = a;
    wd = m_ac;
    case (ins[15:12])
      4'h1: begin m_ac = m_mem[a]; cyc = 6; end
      4'h2: begin m_mem[a] = m_ac; wr = 1'b1; cyc = 5; end
      4'h3: begin m_ac = m_ac + m_mem[a]; cyc = 7; end
      4'h4: begin m_ac = m_ac - m_mem[a]; cyc = 7; end
      4'h7: begin hlt = 1'b1; cyc = 3; end
      4'h8: begin
        sac = m_ac;
        case (ins[1:0])
          2'b00:   take = sac < 0;
          2'b01:   take = sac == 0;
          2'b10:   take = sac > 0;
          default: take = 1'b0;
        endcase
        if (take) m_pc = m_pc + 16'd2;
      end
      4'h9: m_pc = {4'h0, a};
      4'hA: m_ac = 16'h0;
      default: begin
`ifdef ILLEGAL_TRAP_EN
        hlt = 1'b1;
        cyc = 3;
`endif
      end
    endcase
  endtask

  function automatic logic [15:0] rand_word();
    logic [3:0] op;
    int r;
    r = $urandom_range(0, 15);
    case (r)
      0, 1, 2: op = 4'h1;
      3, 4:    op = 4'h2;
      5, 6:    op = 4'h3;
      7, 8:    op = 4'h4;
      9, 10:   op = 4'h8;
      11:      op = 4'h9;
      12:      op = 4'hA;
      13:      op = 4'hF;
      14:      op = 4'h0;
      default: op = 4'h5;
    endcase
    if ($urandom_range(0, 63) == 0) op = 4'h7;
    return {op, 12'($urandom())};
  endfunction

  typedef struct {
    logic [15:0] ins;
    bit          has_d;
    logic [15:0] d;
    logic [15:0] ac;
    logic [15:0] pc;
    int          cyc;
  } vec_t;

  vec_t tbl [$];

  initial begin
    logic [15:0] cur_pc;
    int          e_cyc;
    bit          e_hlt;
    bit          e_wr;
    logic [11:0] e_wa;
    logic [15:0] e_wd;
    logic [15:0] w;

    rst = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 4096; i++) ram[i] = 16'h0;

    tbl.push_back('{16'h111C, 1'b1, 16'h0001, 16'h0001, 16'h0102, 6});
    tbl.push_back('{16'h1130, 1'b1, 16'h0005, 16'h0005, 16'h0104, 6});
    tbl.push_back('{16'h211E, 1'b0, 16'h0000, 16'h0005, 16'h0106, 5});
    tbl.push_back('{16'h1131, 1'b1, 16'h7FFF, 16'h7FFF, 16'h0108, 6});
    tbl.push_back('{16'h3120, 1'b1, 16'h0001, 16'h8000, 16'h010A, 7});
    tbl.push_back('{16'h8001, 1'b0, 16'h0000, 16'h8000, 16'h010C, 4});
    tbl.push_back('{16'h8000, 1'b0, 16'h0000, 16'h8000, 16'h0110, 4});
    tbl.push_back('{16'h4121, 1'b1, 16'h0001, 16'h7FFF, 16'h0112, 7});
    tbl.push_back('{16'h8002, 1'b0, 16'h0000, 16'h7FFF, 16'h0116, 4});
    tbl.push_back('{16'h8003, 1'b0, 16'h0000, 16'h7FFF, 16'h0118, 4});
    tbl.push_back('{16'hA000, 1'b0, 16'h0000, 16'h0000, 16'h011A, 4});
    tbl.push_back('{16'h9100, 1'b0, 16'h0000, 16'h0000, 16'h0100, 4});
    tbl.push_back('{16'h8001, 1'b0, 16'h0000, 16'h0000, 16'h0104, 4});
    tbl.push_back('{16'h311E, 1'b0, 16'h0000, 16'h0005, 16'h0106, 7});
    tbl.push_back('{16'h4122, 1'b1, 16'h0006, 16'hFFFF, 16'h0108, 7});
    tbl.push_back('{16'h8000, 1'b0, 16'h0000, 16'hFFFF, 16'h010C, 4});
    tbl.push_back('{16'h2140, 1'b0, 16'h0000, 16'hFFFF, 16'h010E, 5});
    tbl.push_back('{16'h1140, 1'b0, 16'h0000, 16'hFFFF, 16'h0110, 6});

    do_reset(1'b1);
    cur_pc = 16'h0100;
    foreach (tbl[i]) begin
      ram[cur_pc[11:0]] <= tbl[i].ins;
      if (tbl[i].has_d) ram[tbl[i].ins[11:0]] <= tbl[i].d;
      if (i == 0) pulse_start();
      run_one();
      chk($sformatf("v%0d_done", i), 32'(r_done), 32'd1);
      chk($sformatf("v%0d_cyc", i), 32'(r_cyc), 32'(tbl[i].cyc));
      chk($sformatf("v%0d_pc", i), 32'(pc), 32'(tbl[i].pc));
      chk($sformatf("v%0d_ac", i), 32'(ac), 32'(tbl[i].ac));
      chk($sformatf("v%0d_ir", i), 32'(ir), 32'(tbl[i].ins));
      if (tbl[i].ins[15:12] == 4'h2) begin
        chk($sformatf("v%0d_we_cnt", i), 32'(we_cnt), 32'd1);
        chk($sformatf("v%0d_we_addr", i), 32'(we_addr),
            32'(tbl[i].ins[11:0]));
        chk($sformatf("v%0d_we_data", i), 32'(we_data), 32'(tbl[i].ac));
      end else begin
        chk($sformatf("v%0d_we_cnt", i), 32'(we_cnt), 32'd0);
      end
      if (tbl[i].ins[15:12] == 4'h3)
        chk($sformatf("v%0d_alu_sel", i), 32'(sel6), 32'(ADD_SEL));
      if (tbl[i].ins[15:12] == 4'h4)
        chk($sformatf("v%0d_alu_sel", i), 32'(sel6), 32'(SUB_SEL));
      cur_pc = tbl[i].pc;
    end

    // HALT, then a start pulse must be ignored
    ram[cur_pc[11:0]] <= 16'h7000;
    run_one();
    chk("halt_seen", 32'(r_hlt), 32'd1);
    chk("halt_cyc", 32'(r_cyc), 32'd3);
    chk("halt_flags", 32'({busy, halted}), 32'b01);
    chk("halt_pc", 32'(pc), 32'h0112);
    pulse_start();
    repeat (4) @(negedge clk);
    chk("halt_hold", 32'({busy, halted}), 32'b01);
    chk("halt_hold_pc", 32'(pc), 32'h0112);

    // Asynchronous reset between edges while in WRITE
    do_reset(1'b0);
    ram[12'h100] <= 16'h1130;
    ram[12'h102] <= 16'h2150;
    pulse_start();
    run_one();
    chk("mw_load_ac", 32'(ac), 32'h0005);
    for (int i = 0; i < 10 && !mem_we; i++) @(negedge clk);
    chk("mw_in_write", 32'(mem_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mw_we_drop", 32'({mem_cs, mem_we, mem_oe}), 32'h0);
    chk("mw_pc", 32'(pc), 32'h100);
    chk("mw_ac", 32'(ac), 32'h0);
    chk("mw_idle", 32'({busy, halted, instr_done}), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Undefined opcode 0xF
    do_reset(1'b0);
    ram[12'h100] <= 16'hF123;
    pulse_start();
    run_one();
`ifdef ILLEGAL_TRAP_EN
    chk("ill_halt", 32'(r_hlt), 32'd1);
    chk("ill_no_done", 32'(r_done), 32'd0);
    chk("ill_flags", 32'({busy, halted, illegal_op}), 32'b011);
    pulse_start();
    repeat (3) @(negedge clk);
    chk("ill_sticky", 32'({halted, illegal_op}), 32'b11);
`else
    chk("nop_done", 32'(r_done), 32'd1);
    chk("nop_cyc", 32'(r_cyc), 32'd4);
    chk("nop_pc", 32'(pc), 32'h0102);
    chk("nop_ac", 32'(ac), 32'h0);
    chk("nop_halted", 32'(halted), 32'd0);
`endif

    // Random programs against the instruction-level model
    for (int p = 0; p < 8; p++) begin
      do_reset(1'b0);
      for (int i = 0; i < 4096; i++) begin
        w = rand_word();
        ram[i] <= w;
        m_mem[i] = w;
      end
      m_pc = 16'h0100;
      m_ac = 16'h0;
      pulse_start();
      for (int k = 0; k < 40; k++) begin
        model_step(e_cyc, e_hlt, e_wr, e_wa, e_wd);
        run_one();
        if (e_hlt) begin
          chk($sformatf("p%0d_%0d_halt", p, k), 32'({r_hlt, halted}), 32'b11);
          chk($sformatf("p%0d_%0d_hpc", p, k), 32'(pc), 32'(m_pc));
          break;
        end
        chk($sformatf("p%0d_%0d_done", p, k), 32'(r_done), 32'd1);
        chk($sformatf("p%0d_%0d_cyc", p, k), 32'(r_cyc), 32'(e_cyc));
        chk($sformatf("p%0d_%0d_pc", p, k), 32'(pc), 32'(m_pc));
        chk($sformatf("p%0d_%0d_ac", p, k), 32'(ac), 32'(m_ac));
        chk($sformatf("p%0d_%0d_we", p, k), 32'(we_cnt), 32'(e_wr));
        if (e_wr) begin
          chk($sformatf("p%0d_%0d_wa", p, k), 32'(we_addr), 32'(e_wa));
          chk($sformatf("p%0d_%0d_wd", p, k), 32'(we_data), 32'(e_wd));
        end
        if (!r_done) break;
      end
    end

    @(negedge clk);
    chk("protocol", 32'(proto_err), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/acc_cpu_sequencer.md
Name: acc_cpu_sequencer

Overview:
- Multicycle control unit for the 16-bit accumulator CPU. Owns PC, IR, MBR and AC.
- Sequences fetch/decode/execute against large_ram (chip select, write enable, output enable) and the shared alu (A, B, ALU_Sel).
- Replaces hand-written per-instruction clocking with a reset-able FSM. The test harness only preloads memory and pulses start.

Parameters:
- ADDR_WIDTH, 12: memory address width; mem_addr = low ADDR_WIDTH bits of PC or IR[11:0].
- DATA_WIDTH, 16: word width of memory, IR, MBR, AC, PC.
- RESET_PC, 'h100: PC value at reset.
- ALU_ADD_SEL, 4'h0: alu_sel code for addition.
- ALU_SUB_SEL, 4'h1: alu_sel code for subtraction.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse, IDLE -> FETCH; ignored in every other state.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  RAM write data (= MBR).
- mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after addr/oe presented.
- mem_cs  out  1  chip select; high whenever mem_oe or mem_we is high.
- mem_we  out  1  write enable.
- mem_oe  out  1  output (read) enable.
- alu_a  out  DATA_WIDTH  ALU operand A (= AC).
- alu_b  out  DATA_WIDTH  ALU operand B (= MBR).
- alu_sel  out  4  ALU function select.
- alu_out  in  DATA_WIDTH  combinational ALU result.
- pc  out  DATA_WIDTH  program counter.
- ac  out  DATA_WIDTH  accumulator.
- ir  out  DATA_WIDTH  instruction register.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction.
- illegal_op  out  1  sticky illegal-opcode flag; only present with ILLEGAL_TRAP_EN.

Behaviour:
- Reset (async, any state):
  - state=IDLE, PC=RESET_PC, IR=MBR=AC=0.
  - mem_cs/mem_we/mem_oe=0, alu_a/alu_b=0, alu_sel=ALU_ADD_SEL, instr_done=0, illegal_op=0.
  - Reset in WRITE drops mem_we immediately; no partial state survives.
- Moore control: mem_*, alu_*, busy, halted and instr_done decode from the registered state only.
- States: IDLE, FETCH, FETCH_RD, INCR, OP_ADDR, OP_RD, ALU, WBACK, ST_PREP, WRITE, EXEC1, HALT.
- IDLE: waits for start.
- FETCH: mem_addr=PC, mem_oe=1.
- FETCH_RD: mem_oe held; IR<=mem_rdata.
- INCR: PC<=PC+2 (mod 2^16); next state dispatched on IR[15:12].
- Opcodes:
  - 0x1 LOAD: OP_ADDR (addr=IR[11:0], oe) -> OP_RD (MBR<=rdata) -> WBACK (AC<=MBR). 6 cycles.
  - 0x2 STORE: ST_PREP (MBR<=AC) -> WRITE (addr=IR[11:0], wdata=MBR, we=1, oe=0, exactly one cycle). 5 cycles.
  - 0x3 ADD / 0x4 SUBT: OP_ADDR -> OP_RD -> ALU (alu_a=AC, alu_b=MBR, alu_sel=ADD/SUB code) -> WBACK (AC<=alu_out). 7 cycles. Overflow wraps, no flag.
  - 0x7 HALT: -> HALT. Exits only on rst; start ignored.
  - 0x8 SKIPCOND: EXEC1 with signed AC. IR[1:0]=00 skips if AC<0; 01 if AC==0; 10 if AC>0; 11 never. Skip means PC<=PC+2. 4 cycles.
  - 0x9 JUMP: EXEC1, PC<={4'b0,IR[11:0]}. 4 cycles.
  - 0xA CLEAR: EXEC1, AC<=0. 4 cycles.
  - Other opcodes: see Optional Feature.
- After the last cycle of each instruction -> FETCH; instr_done is high in that cycle.
- mem_oe and mem_we are never high together. mem_we is high only in WRITE.
- HALT: busy=0, halted=1; all memory controls low.

Optional Feature:
- ILLEGAL_TRAP_EN defined: an undefined opcode in INCR -> HALT with illegal_op=1 (sticky until rst). instr_done does not pulse.
- Undefined: undefined opcodes act as a 4-cycle NOP via EXEC1 with instr_done pulse. The illegal_op port is absent.

Test Plan:
- rst, start; mem[0x100]=0x111C, mem[0x11C]=0x0001 -> 6 cycles after FETCH entry AC=0x0001, PC=0x0102, one instr_done pulse.
- AC=0x0005, STORE 0x211E -> mem_we high exactly one cycle, mem_addr=0x11E, mem_wdata=0x0005, mem_oe=0 that cycle.
- AC=0x7FFF, ADD 0x3120 with mem[0x120]=0x0001 -> alu_sel=ALU_ADD_SEL in ALU state, AC=0x8000, 7 cycles.
- SKIPCOND 0x8001 with AC=0 -> PC advances by 4. Same with AC=0x8000 -> advances by 2. 0x8000 with AC=0x8000 -> skip.
- JUMP 0x9100 -> PC=0x0100. HALT 0x7000 -> halted=1, busy=0; a later start pulse has no effect.
- rst asserted mid-WRITE (asynchronous, between edges) -> mem_we=0 immediately, PC=RESET_PC, state IDLE. Opcode 0xF -> NOP without macro, halted=1/illegal_op=1 with ILLEGAL_TRAP_EN.
